pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//   Central stall/flush sequencer for the 5-stage 64-bit pipelined CPU. Detects load-use hazards the
//   forwarding unit cannot cover and inserts a one-cycle bubble. Squashes the IF/RF instruction on a
//   taken branch. Freezes the whole pipeline while a multi-cycle data-memory access completes, with a
//   watchdog that traps to an error state. Drives the enables of the PC and every pipe register.
// PARAMETERS
//   REG_W       5    register-index width
//   MEM_TIMEOUT 16   max consecutive data-memory wait cycles before ERR (>=2)
//   CNT_W       16   width of stall performance counter
// PORTS
//   clk            in   1      rising-edge clock
//   reset          in   1      asynchronous reset, active-low (asserted when 0)
//   rf_rn          in   REG_W  Rn of instruction in RF
//   rf_rm          in   REG_W  second read index (post Reg2Loc mux) in RF
//   rf_uses_rn     in   1      RF instruction reads Rn
//   rf_uses_rm     in   1      RF instruction reads second operand register
//   rf_br_taken    in   1      branch in RF resolved taken (BrTaken)
//   ex_rd          in   REG_W  destination of instruction in EX
//   ex_mem_read    in   1      EX instruction is a load (LDUR/LDURB)
//   ex_reg_write   in   1      EX instruction writes a register
//   mem_access     in   1      MEM stage holds a load or store
//   mem_ready      in   1      data memory completes access this cycle
//   stat_clr       in   1      synchronous clear of stall_cnt
//   pc_en          out  1      PC register load enable
//   ifrf_en        out  1      IF/RF pipe enable
//   ifrf_flush     out  1      load NOP (32'h0) into IF/RF instead of fetched word
//   rfex_en        out  1      RF/EX pipe enable
//   rfex_bubble    out  1      zero all control bits entering RF/EX (RegWrite, MemWrite, flagSet, read_en)
//   exmem_en       out  1      EX/MEM pipe enable
//   memwb_en       out  1      MEM/WB pipe enable
//   state_o        out  2      current FSM state (debug)
//   stall_cnt      out  CNT_W  saturating count of cycles with pc_en=0
//   mem_timeout_err out 1      sticky watchdog error
// BEHAVIOUR
//   - States: RUN=0, MEM_WAIT=1, ERR=2. Reset -> RUN, wait_cnt=0, stall_cnt=0, mem_timeout_err=0.
//   - While reset=0: all enables 0, rfex_bubble=1, ifrf_flush=0, independent of other inputs.
//   - Outputs are Mealy (combinational on same-cycle inputs + state); state/counters registered.
//   - Load-use hit LU = ex_mem_read & ex_reg_write & ex_rd!=31 &
//       ((rf_uses_rn & rf_rn==ex_rd) | (rf_uses_rm & rf_rm==ex_rd)). Register 31 (XZR) never hazards.
//   - Memory wait MW = mem_access & ~mem_ready.
//   - Priority: ERR > MW freeze > LU stall > branch flush.
//   - RUN, MW: all five enables 0 (full freeze); next = MEM_WAIT, wait_cnt <= 1.
//   - RUN, ~MW, LU: pc_en=ifrf_en=0, rfex_en=1, rfex_bubble=1, exmem_en=memwb_en=1; one cycle only
//     (load advances to MEM, forwarded from WriteDataMem next cycle). rf_br_taken ignored this cycle.
//   - RUN, ~MW, ~LU, rf_br_taken: all enables 1, ifrf_flush=1.
//   - RUN, none: all enables 1, no bubble, no flush.
//   - MEM_WAIT: mem_ready=1 -> behave as RUN this cycle (LU/flush rules apply), next RUN, wait_cnt<=0.
//     mem_ready=0 -> full freeze; if wait_cnt==MEM_TIMEOUT-1 next ERR else wait_cnt++.
//   - ERR: all enables 0, rfex_bubble=1, mem_timeout_err=1; exits only on reset.
//   - Frozen MEM/WB repeats same regfile write: idempotent, required as-is.
//   - stall_cnt: +1 each cycle pc_en=0 and reset=1, saturates at all-ones; stat_clr wins over increment.
//   - Reset mid-MEM_WAIT: immediate return to RUN, counters cleared, no partial state retained.
// TESTING
//   1 LDUR X3 in EX (ex_rd=3), ADD reads rf_rn=3 -> 1 cycle pc_en=0, rfex_bubble=1; next cycle all en=1.
//   2 Load to X31 with rf_rn=31 -> no stall; load-hit with rf_uses_rm=0, rf_rm=ex_rd -> no stall.
//   3 rf_br_taken=1 alone -> ifrf_flush=1, pc_en=1; same cycle with LU -> flush=0, stall wins.
//   4 mem_access=1, mem_ready low 3 cycles then high -> 3 freeze cycles, stall_cnt=3, state back to RUN.
//   5 mem_ready held low, MEM_TIMEOUT=16 -> state ERR after 16 freeze cycles, err=1 sticky until reset=0.
//   6 reset=0 during MEM_WAIT -> enables 0 immediately; after release state RUN, counters 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: load-use bubbles,
// taken-branch squash, data-memory wait freeze with a timeout watchdog.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_W       = 5,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rf_rn,
  input  logic [REG_W-1:0] rf_rm,
  input  logic             rf_uses_rn,
  input  logic             rf_uses_rm,
  input  logic             rf_br_taken,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic             mem_access,
  input  logic             mem_ready,
  input  logic             stat_clr,
  output logic             pc_en,
  output logic             ifrf_en,
  output logic             ifrf_flush,
  output logic             rfex_en,
  output logic             rfex_bubble,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             mem_timeout_err
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT);
  localparam logic [REG_W-1:0] XZR = REG_W'(31);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    stall_q;
  logic                lu_hit;
  logic                mem_wait;
  logic                freeze;

  // Hazard terms: XZR is never a real dependency
  assign lu_hit = ex_mem_read & ex_reg_write & (ex_rd != XZR) &
                  ((rf_uses_rn & (rf_rn == ex_rd)) | (rf_uses_rm & (rf_rm == ex_rd)));
  assign mem_wait = mem_access & ~mem_ready;

  // Once waiting, only mem_ready releases the freeze
  assign freeze = (state_q == ST_RUN) ? mem_wait : ~mem_ready;

  // State and watchdog registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  // Next-state and wait-counter logic
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    case (state_q)
      ST_RUN: begin
        if (mem_wait) begin
          state_d = ST_MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_ERR: begin
        err_d = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase
  end

  // Mealy enable/bubble/flush decode; reset forces a safe frozen pipe
  always_comb begin
    pc_en       = 1'b0;
    ifrf_en     = 1'b0;
    ifrf_flush  = 1'b0;
    rfex_en     = 1'b0;
    rfex_bubble = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    if (!reset) begin
      rfex_bubble = 1'b1;
    end else begin
      case (state_q)
        ST_RUN, ST_MEM_WAIT: begin
          if (!freeze) begin
            rfex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            if (lu_hit) begin
              rfex_bubble = 1'b1;
            end else begin
              pc_en      = 1'b1;
              ifrf_en    = 1'b1;
              ifrf_flush = rf_br_taken;
            end
          end
        end
        default: begin
          rfex_bubble = 1'b1;
        end
      endcase
    end
  end

  // Saturating count of cycles with the PC held; clear beats increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (stat_clr) begin
      stall_q <= '0;
    end else if (!pc_en && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign state_o         = state_q;
  assign stall_cnt       = stall_q;
  assign mem_timeout_err = err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: decode table plus multi-cycle sequences.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 5;

  // Expected output patterns: {pc, ifrf, flush, rfex, bubble, exmem, memwb}
  localparam logic [6:0] P_NORM  = 7'b1101011;
  localparam logic [6:0] P_FLUSH = 7'b1111011;
  localparam logic [6:0] P_STALL = 7'b0001111;
  localparam logic [6:0] P_SAFE  = 7'b0000100;
  localparam logic [6:0] M_ALL   = 7'b1111111;
  localparam logic [6:0] M_FRZ   = 7'b1111011;

  logic clk, reset;
  logic [REG_W-1:0] rf_rn, rf_rm, ex_rd;
  logic rf_uses_rn, rf_uses_rm, rf_br_taken, ex_mem_read, ex_reg_write;
  logic mem_access, mem_ready, stat_clr;
  logic pc_en, ifrf_en, ifrf_flush, rfex_en, rfex_bubble, exmem_en, memwb_en;
  logic [1:0] state_o;
  logic [CNT_W-1:0] stall_cnt;
  logic mem_timeout_err;

  int checks;
  int failures;

  pipeline_hazard_ctrl #(.REG_W(REG_W), .MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .rf_rn(rf_rn), .rf_rm(rf_rm), .rf_uses_rn(rf_uses_rn), .rf_uses_rm(rf_uses_rm),
    .rf_br_taken(rf_br_taken), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .mem_access(mem_access), .mem_ready(mem_ready),
    .stat_clr(stat_clr), .pc_en(pc_en), .ifrf_en(ifrf_en), .ifrf_flush(ifrf_flush),
    .rfex_en(rfex_en), .rfex_bubble(rfex_bubble), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .state_o(state_o), .stall_cnt(stall_cnt),
    .mem_timeout_err(mem_timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rn;
    logic [4:0] rm;
    logic       urn;
    logic       urm;
    logic       br;
    logic [4:0] rd;
    logic       mr;
    logic       rw;
    logic       ma;
    logic       mrdy;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic [4:0] rn, input logic [4:0] rm, input logic urn,
                              input logic urm, input logic br, input logic [4:0] rd,
                              input logic mr, input logic rw, input logic ma,
                              input logic mrdy, input logic [6:0] exp);
    vec_t v;
    v.rn = rn; v.rm = rm; v.urn = urn; v.urm = urm; v.br = br; v.rd = rd;
    v.mr = mr; v.rw = rw; v.ma = ma; v.mrdy = mrdy; v.exp = exp;
    return v;
  endfunction

  function automatic logic [6:0] outs();
    return {pc_en, ifrf_en, ifrf_flush, rfex_en, rfex_bubble, exmem_en, memwb_en};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string name, input logic [6:0] exp, input logic [6:0] mask);
    chk(name, 32'(outs() & mask), 32'(exp & mask));
  endtask

  task automatic idle_inputs();
    rf_rn = '0; rf_rm = '0; rf_uses_rn = 0; rf_uses_rm = 0; rf_br_taken = 0;
    ex_rd = '0; ex_mem_read = 0; ex_reg_write = 0;
    mem_access = 0; mem_ready = 0; stat_clr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    idle_inputs();

    vecs[0]  = mk(5'd1, 5'd2, 1, 1, 0, 5'd3, 1, 1, 0, 0, P_NORM);   // load, no dependency
    vecs[1]  = mk(5'd3, 5'd2, 1, 1, 0, 5'd3, 1, 1, 0, 0, P_STALL);  // Rn hit
    vecs[2]  = mk(5'd5, 5'd3, 1, 1, 0, 5'd3, 1, 1, 0, 0, P_STALL);  // Rm hit
    vecs[3]  = mk(5'd31, 5'd2, 1, 1, 0, 5'd31, 1, 1, 0, 0, P_NORM); // XZR never hazards
    vecs[4]  = mk(5'd1, 5'd7, 1, 0, 0, 5'd7, 1, 1, 0, 0, P_NORM);   // Rm match but unused
    vecs[5]  = mk(5'd7, 5'd1, 0, 1, 0, 5'd7, 1, 1, 0, 0, P_NORM);   // Rn match but unused
    vecs[6]  = mk(5'd4, 5'd4, 1, 1, 0, 5'd4, 0, 1, 0, 0, P_NORM);   // ALU producer, forwarded
    vecs[7]  = mk(5'd4, 5'd4, 1, 1, 0, 5'd4, 1, 0, 0, 0, P_NORM);   // no register write
    vecs[8]  = mk(5'd1, 5'd2, 1, 1, 1, 5'd3, 0, 0, 0, 0, P_FLUSH);  // taken branch alone
    vecs[9]  = mk(5'd3, 5'd2, 1, 1, 1, 5'd3, 1, 1, 0, 0, P_STALL);  // stall beats flush
    vecs[10] = mk(5'd1, 5'd2, 1, 1, 1, 5'd9, 1, 1, 0, 0, P_FLUSH);  // branch + harmless load
    vecs[11] = mk(5'd6, 5'd2, 1, 1, 0, 5'd6, 1, 1, 1, 1, P_STALL);  // mem done + hit
    vecs[12] = mk(5'd1, 5'd2, 1, 1, 0, 5'd6, 1, 1, 1, 1, P_NORM);   // mem done, no hit
    vecs[13] = mk(5'd4, 5'd2, 1, 0, 0, 5'd3, 1, 1, 0, 0, P_NORM);   // near miss on index

    // Reset holds a safe frozen pipe regardless of inputs
    reset = 1'b0;
    rf_br_taken = 1; mem_access = 1;
    #12;
    chk_outs("reset_outs", P_SAFE, M_ALL);
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset_err", 32'(mem_timeout_err), 32'd0);
    idle_inputs();
    #1 reset = 1'b1;
    tick();

    // Single-cycle decode table in RUN
    for (int i = 0; i < 14; i++) begin
      rf_rn = vecs[i].rn; rf_rm = vecs[i].rm; rf_uses_rn = vecs[i].urn;
      rf_uses_rm = vecs[i].urm; rf_br_taken = vecs[i].br; ex_rd = vecs[i].rd;
      ex_mem_read = vecs[i].mr; ex_reg_write = vecs[i].rw;
      mem_access = vecs[i].ma; mem_ready = vecs[i].mrdy;
      #2;
      chk_outs($sformatf("vec%0d_outs", i), vecs[i].exp, M_ALL);
      chk($sformatf("vec%0d_state", i), 32'(state_o), 32'd0);
      tick();
    end

    // Load-use bubble lasts one cycle, then the load has moved on
    idle_inputs();
    ex_rd = 5'd3; ex_mem_read = 1; ex_reg_write = 1; rf_rn = 5'd3; rf_uses_rn = 1;
    stat_clr = 1;
    #2 chk_outs("lu_stall", P_STALL, M_ALL);
    tick();
    ex_mem_read = 0; ex_reg_write = 0; ex_rd = 5'd8; stat_clr = 0;
    #2 chk_outs("lu_release", P_NORM, M_ALL);
    tick();

    // Clear stats, then three memory wait cycles
    idle_inputs();
    stat_clr = 1;
    tick();
    stat_clr = 0;
    chk("clr_stall_cnt", 32'(stall_cnt), 32'd0);
    mem_access = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk_outs($sformatf("mw_freeze%0d", i), 7'b0, M_FRZ);
      chk($sformatf("mw_state%0d", i), 32'(state_o), (i == 0) ? 32'd0 : 32'd1);
      tick();
    end
    mem_ready = 1;
    #2 chk_outs("mw_release", P_NORM, M_ALL);
    tick();
    mem_access = 0; mem_ready = 0;
    chk("mw_state_after", 32'(state_o), 32'd0);
    chk("mw_stall_cnt", 32'(stall_cnt), 32'd3);

    // Watchdog: memory never answers
    mem_access = 1; mem_ready = 0;
    for (int i = 0; i < 16; i++) begin
      #2;
      chk_outs($sformatf("to_freeze%0d", i), 7'b0, M_FRZ);
      chk($sformatf("to_state%0d", i), 32'(state_o), (i == 0) ? 32'd0 : 32'd1);
      chk($sformatf("to_err%0d", i), 32'(mem_timeout_err), 32'd0);
      tick();
    end
    #2;
    chk("to_state_err", 32'(state_o), 32'd2);
    chk("to_err_set", 32'(mem_timeout_err), 32'd1);
    mem_access = 0; mem_ready = 1; rf_br_taken = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_outs($sformatf("err_outs%0d", i), P_SAFE, M_ALL);
      tick();
    end
    chk("err_sticky", 32'(mem_timeout_err), 32'd1);
    chk("err_state_sticky", 32'(state_o), 32'd2);
    chk("err_stall_cnt", 32'(stall_cnt), 32'd22);

    // Saturation at 31 and clear priority over increment
    for (int i = 0; i < 12; i++) tick();
    chk("stall_sat", 32'(stall_cnt), 32'd31);
    stat_clr = 1;
    tick();
    chk("stall_clr_wins", 32'(stall_cnt), 32'd0);
    stat_clr = 0;
    tick();
    chk("stall_after_clr", 32'(stall_cnt), 32'd1);

    // Only reset leaves ERR
    reset = 1'b0;
    #1;
    chk("err_rst_state", 32'(state_o), 32'd0);
    chk("err_rst_err", 32'(mem_timeout_err), 32'd0);
    chk("err_rst_cnt", 32'(stall_cnt), 32'd0);
    idle_inputs();
    #2 reset = 1'b1;
    tick();

    // Reset in the middle of a memory wait
    mem_access = 1; mem_ready = 0;
    tick();
    tick();
    chk("mid_state_wait", 32'(state_o), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk_outs("mid_rst_outs", P_SAFE, M_ALL);
    chk("mid_rst_state", 32'(state_o), 32'd0);
    chk("mid_rst_cnt", 32'(stall_cnt), 32'd0);
    idle_inputs();
    #1 reset = 1'b1;
    tick();
    #2;
    chk_outs("mid_after_outs", P_NORM, M_ALL);
    chk("mid_after_state", 32'(state_o), 32'd0);
    chk("mid_after_cnt", 32'(stall_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
